seven_seg_scan_ctrl: RTL and testbench

Parametrised N-digit multiplexed 7-segment display controller. It is the successor to the fixed 4-digit scan driver in the lab display path.
- Adds tear-free double-buffered loading with a handshake, hex or decimal decoding, and leading-zero suppression.
- Adds per-digit decimal points, per-digit blink, and PWM brightness control.
- Sits between the arithmetic/result datapath and the board anode/cathode pins.

---
 rtl/seven_seg_scan_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller.
// Scans one digit per dwell period, decodes hex/decimal codes with optional
// leading-zero suppression, per-digit decimal points and blink, and PWM
// dimming. New digit data is staged and only swapped into the displayed
// copy at a frame boundary, so a frame is never torn.
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_BITS = 11,
   parameter int BLINK_BITS   = 24
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   output logic                    load_ack,
   input  logic                    hex_mode,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   blink_en,
   input  logic [3:0]              brightness,
   output logic [NUM_DIGITS-1:0]   anode_act,
   output logic [6:0]              led_out,
   output logic                    dp_out,
   output logic                    frame_start
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0] SEG_DASH = 7'b1111110;

   // Scan timing state
   logic [REFRESH_BITS-1:0] dwell_reg;
   logic [IDX_W-1:0]        idx_reg;
   logic [BLINK_BITS-1:0]   blink_cnt_reg;
   logic                    blink_off_reg;

   // Double-buffered digit data
   logic [4*NUM_DIGITS-1:0] stage_digits_reg;
   logic [NUM_DIGITS-1:0]   stage_dp_reg;
   logic                    pending_reg;
   logic [4*NUM_DIGITS-1:0] disp_digits_reg;
   logic [NUM_DIGITS-1:0]   disp_dp_reg;

   // Registered pin drivers
   logic [NUM_DIGITS-1:0]   anode_reg;
   logic [6:0]              led_reg;
   logic                    dp_reg;
   logic                    load_ack_reg;
   logic                    frame_start_reg;

   logic [NUM_DIGITS-1:0]   anode_next;
   logic [6:0]              led_next;
   logic                    dp_next;

   logic                    dwell_wrap;
   logic                    boundary;
   logic                    transfer;
   logic [3:0]              disp_digit [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   tail_zero;
   logic                    tail_run;
   logic [3:0]              cur_code;
   logic                    cur_dp;
   logic [6:0]              seg_code;
   logic                    pwm_on;
   logic                    blink_dark;
   logic                    lz_blank;

   assign dwell_wrap = &dwell_reg;
   assign boundary   = dwell_wrap && (idx_reg == LAST_IDX);
   // A load on the boundary cycle keeps the data pending for another frame
   assign transfer   = boundary && pending_reg && !load;

   // Slice the displayed word into per-digit codes
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign disp_digit[gi] = disp_digits_reg[4*gi +: 4];
      end
   endgenerate

   // Dwell counter and digit index; index advances when the dwell wraps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dwell_reg <= '0;
         idx_reg   <= '0;
      end else begin
         dwell_reg <= dwell_reg + 1'b1;
         if (dwell_wrap)
            idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
      end
   end

   // Blink phase toggles every time the blink counter wraps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_reg <= '0;
         blink_off_reg <= 1'b0;
      end else begin
         blink_cnt_reg <= blink_cnt_reg + 1'b1;
         if (&blink_cnt_reg)
            blink_off_reg <= ~blink_off_reg;
      end
   end

   // Staging/display handshake: latest load wins, swap only at a frame boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_digits_reg <= '0;
         stage_dp_reg     <= '0;
         pending_reg      <= 1'b0;
         disp_digits_reg  <= '0;
         disp_dp_reg      <= '0;
         load_ack_reg     <= 1'b0;
      end else begin
         load_ack_reg <= transfer;
         if (load) begin
            stage_digits_reg <= digits_in;
            stage_dp_reg     <= dp_in;
            pending_reg      <= 1'b1;
         end else if (transfer) begin
            disp_digits_reg <= stage_digits_reg;
            disp_dp_reg     <= stage_dp_reg;
            pending_reg     <= 1'b0;
         end
      end
   end

   // tail_zero[k] is set when displayed digits k..NUM_DIGITS-1 are all zero
   always_comb begin
      tail_zero = '0;
      tail_run  = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         tail_run     = tail_run && (disp_digits_reg[4*k +: 4] == 4'd0);
         tail_zero[k] = tail_run;
      end
   end

   assign cur_code   = disp_digit[idx_reg];
   assign cur_dp     = disp_dp_reg[idx_reg];
   assign pwm_on     = (dwell_reg[REFRESH_BITS-1 -: 4] <= brightness);
   assign blink_dark = blink_off_reg && blink_en[idx_reg];
   assign lz_blank   = blank_lz && (idx_reg != '0) && tail_zero[idx_reg];

   // Code to active-low segment pattern (a..g = bit6..bit0)
   always_comb begin
      seg_code = SEG_DASH;
      case (cur_code)
         4'h0: seg_code = 7'b0000001;
         4'h1: seg_code = 7'b1001111;
         4'h2: seg_code = 7'b0010010;
         4'h3: seg_code = 7'b0000110;
         4'h4: seg_code = 7'b1001100;
         4'h5: seg_code = 7'b0100100;
         4'h6: seg_code = 7'b0100000;
         4'h7: seg_code = 7'b0001111;
         4'h8: seg_code = 7'b0000000;
         4'h9: seg_code = 7'b0000100;
         4'hA: seg_code = hex_mode ? 7'b0001000 : SEG_DASH;
         4'hB: seg_code = hex_mode ? 7'b1100000 : SEG_DASH;
         4'hC: seg_code = hex_mode ? 7'b0110001 : SEG_DASH;
         4'hD: seg_code = hex_mode ? 7'b1000010 : SEG_DASH;
         4'hE: seg_code = hex_mode ? 7'b0110000 : SEG_DASH;
         4'hF: seg_code = hex_mode ? 7'b0111000 : SEG_DASH;
         default: seg_code = SEG_DASH;
      endcase
   end

   // Pin values for the current digit; dark unless PWM and blink allow it
   always_comb begin
      anode_next = '1;
      led_next   = 7'h7F;
      dp_next    = 1'b1;
      if (pwm_on && !blink_dark) begin
         if (!lz_blank) begin
            anode_next[idx_reg] = 1'b0;
            led_next            = seg_code;
            dp_next             = ~cur_dp;
         end else if (cur_dp) begin
            anode_next[idx_reg] = 1'b0;
            dp_next             = 1'b0;
         end
      end
   end

   // Anode, segments and dp registered together so they switch in one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         anode_reg       <= '1;
         led_reg         <= 7'h7F;
         dp_reg          <= 1'b1;
         frame_start_reg <= 1'b0;
      end else begin
         anode_reg       <= anode_next;
         led_reg         <= led_next;
         dp_reg          <= dp_next;
         frame_start_reg <= boundary;
      end
   end

   assign anode_act   = anode_reg;
   assign led_out     = led_reg;
   assign dp_out      = dp_reg;
   assign load_ack    = load_ack_reg;
   assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Scoreboard bench for seven_seg_scan_ctrl (4 digits, 32-clock dwell,
// 256-clock blink phase). A reference model derives every expected pin value
// from the elapsed cycle count since reset and pushes it into a queue; an
// independent monitor pops and compares one entry per clock.
module tb_seven_seg_scan_ctrl;

   localparam int ND = 4;
   localparam int RB = 5;
   localparam int BB = 8;
   localparam int DWELL = 1 << RB;
   localparam int FRAME = DWELL * ND;
   localparam int BLINK = 1 << BB;

   logic            clk;
   logic            rst;
   logic [4*ND-1:0] digits_in;
   logic [ND-1:0]   dp_in;
   logic            load;
   logic            load_ack;
   logic            hex_mode;
   logic            blank_lz;
   logic [ND-1:0]   blink_en;
   logic [3:0]      brightness;
   logic [ND-1:0]   anode_act;
   logic [6:0]      led_out;
   logic            dp_out;
   logic            frame_start;

   typedef struct packed {
      logic [ND-1:0] an;
      logic [6:0]    led;
      logic          dp;
      logic          fs;
      logic          ack;
   } exp_t;

   exp_t        exp_q [$];
   int          total;
   int          bad;
   int unsigned model_t;
   logic [6:0]  seg_tab [16];

   seven_seg_scan_ctrl #(
      .NUM_DIGITS  (ND),
      .REFRESH_BITS(RB),
      .BLINK_BITS  (BB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .load       (load),
      .load_ack   (load_ack),
      .hex_mode   (hex_mode),
      .blank_lz   (blank_lz),
      .blink_en   (blink_en),
      .brightness (brightness),
      .anode_act  (anode_act),
      .led_out    (led_out),
      .dp_out     (dp_out),
      .frame_start(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111;
      seg_tab[2]  = 7'b0010010; seg_tab[3]  = 7'b0000110;
      seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
      seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111;
      seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0000100;
      seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
      seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010;
      seg_tab[14] = 7'b0110000; seg_tab[15] = 7'b0111000;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s t=%0d actual=%h required=%h", name, model_t, act, req);
      end
   endtask

   // Reference model: one expected pin set per rising edge
   initial begin
      logic [4*ND-1:0] stg_d, disp_d;
      logic [ND-1:0]   stg_p, disp_p, oh;
      bit              pend, boundary, lz, pwm, bdark;
      int              dwell, idx, code;
      exp_t            e;
      stg_d = '0; disp_d = '0; stg_p = '0; disp_p = '0; pend = 0; model_t = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            stg_d = '0; disp_d = '0; stg_p = '0; disp_p = '0; pend = 0; model_t = 0;
            e = '{an: '1, led: 7'h7F, dp: 1'b1, fs: 1'b0, ack: 1'b0};
         end else begin
            dwell    = int'(model_t % DWELL);
            idx      = int'((model_t / DWELL) % ND);
            boundary = (model_t % FRAME) == FRAME - 1;
            code     = int'((disp_d >> (4 * idx)) & 16'hF);
            lz       = blank_lz && (idx > 0);
            for (int k = idx; k < ND; k++)
               if (((disp_d >> (4 * k)) & 16'hF) != 0) lz = 0;
            pwm      = (dwell / (DWELL / 16)) <= int'(brightness);
            bdark    = blink_en[idx] && (((model_t / BLINK) % 2) == 1);
            oh       = ND'(1) << idx;
            e        = '{an: '1, led: 7'h7F, dp: 1'b1, fs: boundary, ack: 1'b0};
            if (pwm && !bdark) begin
               if (!lz) begin
                  e.an  = ~oh;
                  e.led = (hex_mode || code < 10) ? seg_tab[code] : 7'b1111110;
                  e.dp  = ~disp_p[idx];
               end else if (disp_p[idx]) begin
                  e.an = ~oh;
                  e.dp = 1'b0;
               end
            end
            if (load) begin
               stg_d = digits_in; stg_p = dp_in; pend = 1;
            end else if (boundary && pend) begin
               disp_d = stg_d; disp_p = stg_p; pend = 0; e.ack = 1'b1;
            end
            model_t++;
         end
         exp_q.push_back(e);
      end
   end

   // Monitor: compare DUT pins against the queued expectation each clock
   initial begin
      exp_t e;
      total = 0;
      bad   = 0;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("anode_act",   32'(anode_act),   32'(e.an));
            chk("led_out",     32'(led_out),     32'(e.led));
            chk("dp_out",      32'(dp_out),      32'(e.dp));
            chk("frame_start", 32'(frame_start), 32'(e.fs));
            chk("load_ack",    32'(load_ack),    32'(e.ack));
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Advance until the next posedge will see the given position in the frame
   task automatic wait_phase(input int pos);
      int n;
      n = 0;
      while (int'(model_t % FRAME) != pos && n < 2 * FRAME) begin
         @(negedge clk);
         n++;
      end
      if (int'(model_t % FRAME) != pos)
         chk("phase_timeout", 32'(model_t % FRAME), 32'(pos));
   endtask

   task automatic do_load(input logic [4*ND-1:0] d, input logic [ND-1:0] p);
      load      = 1'b1;
      digits_in = d;
      dp_in     = p;
      @(negedge clk);
      load = 1'b0;
   endtask

   function automatic logic [4*ND-1:0] rand_digits();
      logic [4*ND-1:0] v;
      v = '0;
      for (int k = 0; k < ND; k++)
         if ($urandom_range(0, 1) == 1) v[4*k +: 4] = 4'($urandom_range(0, 15));
      return v;
   endfunction

   // Stimulus
   initial begin
      rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0;
      hex_mode = 1'b1; blank_lz = 1'b0; blink_en = '0; brightness = 4'd15;
      cycles(3);
      rst = 1'b0;

      // Zero display, full brightness: plain scan of '0'
      cycles(2 * FRAME + 20);

      // Mid-frame load, then hex letters, then dash mode
      wait_phase(40);
      do_load(16'h12A9, 4'b0000);
      cycles(FRAME + 40);
      hex_mode = 1'b0;
      cycles(FRAME + 10);
      hex_mode = 1'b1;

      // Leading-zero suppression with a dp on a blanked digit
      blank_lz = 1'b1;
      do_load(16'h0050, 4'b1000);
      cycles(2 * FRAME + 10);

      // PWM dimming
      brightness = 4'd3;
      cycles(FRAME + 20);
      brightness = 4'd0;
      cycles(FRAME);
      brightness = 4'd15;

      // Blink on digit 0
      blink_en = 4'b0001;
      cycles(3 * BLINK);
      blink_en = 4'b0000;

      // Load on the boundary cycle defers a frame; reset discards it
      wait_phase(FRAME - 1);
      do_load(16'h3456, 4'b0101);
      cycles(FRAME + 30);
      do_load(16'h789B, 4'b0010);
      cycles(20);
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(2 * FRAME + 10);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 40) == 0) begin
            load      = 1'b1;
            digits_in = rand_digits();
            dp_in     = ND'($urandom_range(0, (1 << ND) - 1));
         end else begin
            load = 1'b0;
         end
         if ($urandom_range(0, 90) == 0) begin
            hex_mode   = 1'($urandom_range(0, 1));
            blank_lz   = 1'($urandom_range(0, 1));
            blink_en   = ND'($urandom_range(0, (1 << ND) - 1));
            brightness = 4'($urandom_range(0, 15));
         end
         if (i % 500 == 499) begin
            wait_phase(FRAME - 1);
            do_load(rand_digits(), ND'($urandom_range(0, (1 << ND) - 1)));
         end
         @(negedge clk);
      end
      load = 1'b0;
      cycles(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
